// File: rtl/addr_decoder_ws_if.sv
// CPU data-port side of the address decoder: request/address in,
// chip selects and completion handshake out.
interface addr_decoder_ws_if #(
    parameter int NREG = 4
);
    logic            REQ;
    logic [31:0]     ADDR;
    logic [NREG-1:0] CS_N;
    logic [2:0]      SEL;
    logic            ACK;
    logic            ERR;
    logic            STALL;

    modport master (
        output REQ, ADDR,
        input  CS_N, SEL, ACK, ERR, STALL
    );

    modport slave (
        input  REQ, ADDR,
        output CS_N, SEL, ACK, ERR, STALL
    );
endinterface

// File: rtl/addr_decoder_ws.sv
// Multi-region address decoder holding one active-low chip select per access
// for a per-region number of wait cycles; stalls the CPU until the access completes.
module addr_decoder_ws #(
    parameter int                  NREG  = 4,
    parameter logic [NREG*32-1:0]  BASE  = {32'h0000_4F00, 32'h0000_FF00, 32'h0000_8000, 32'h0000_4B00},
    parameter logic [NREG*32-1:0]  LIMIT = {32'h0000_5300, 32'h0000_FF10, 32'h0000_9000, 32'h0000_4F00},
    parameter logic [NREG*4-1:0]   WS    = {4'd3, 4'd1, 4'd2, 4'd0}
) (
    input  logic            CLK,
    input  logic            RST,
    addr_decoder_ws_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [2:0]      sel_q, sel_d;
    logic [NREG-1:0] cs_n_q, cs_n_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;

    logic [NREG-1:0] hit;
    logic            hit_any;
    logic [2:0]      hit_idx;
    logic [3:0]      hit_ws;
    logic [NREG-1:0] hit_cs_n;

    // Unsigned range compare per region; LIMIT <= BASE yields an empty range.
    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            hit[k] = (bus.ADDR >= BASE[32*k +: 32]) && (bus.ADDR < LIMIT[32*k +: 32]);
        end
    end

    // Scan from the top so the lowest matching index is the one that sticks.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = 3'd0;
        for (int k = NREG-1; k >= 0; k--) begin
            if (hit[k]) begin
                hit_any = 1'b1;
                hit_idx = 3'(k);
            end
        end
    end

    always_comb begin
        hit_ws   = 4'd0;
        hit_cs_n = '1;
        for (int k = 0; k < NREG; k++) begin
            if (hit_idx == 3'(k)) begin
                hit_ws      = WS[4*k +: 4];
                hit_cs_n[k] = 1'b0;
            end
        end
    end

    // Outputs are computed as next-state values so CS_N/ACK/ERR come straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        cs_n_d  = cs_n_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_n_d = '1;
                if (bus.REQ) begin
                    if (hit_any) begin
                        state_d = S_ACCESS;
                        sel_d   = hit_idx;
                        cnt_d   = hit_ws;
                        cs_n_d  = hit_cs_n;
                        ack_d   = (hit_ws == 4'd0);
                    end else begin
                        state_d = S_ERROR;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end

            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    ack_d = (cnt_q == 4'd1);
                end else begin
                    state_d = S_IDLE;
                    cs_n_d  = '1;
                end
            end

            S_ERROR: begin
                state_d = S_IDLE;
                cs_n_d  = '1;
            end

            default: begin
                state_d = S_IDLE;
                cs_n_d  = '1;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 3'd0;
            cs_n_q  <= '1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            cs_n_q  <= cs_n_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.CS_N  = cs_n_q;
    assign bus.SEL   = sel_q;
    assign bus.ACK   = ack_q;
    assign bus.ERR   = err_q;
    assign bus.STALL = bus.REQ & ~ack_q;

endmodule

// File: tb/tb_addr_decoder_ws.sv
// Directed bench for addr_decoder_ws: region hits, wait-state lengths, boundaries,
// unmapped accesses, mid-access address change, back-to-back and async reset.
module tb_addr_decoder_ws;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    addr_decoder_ws_if #(.NREG(4)) bus ();

    addr_decoder_ws dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a request from IDLE and follows it cycle by cycle to completion.
    task automatic access(input string tag, input logic [31:0] addr,
                          input logic [3:0] exp_cs, input logic [2:0] exp_sel,
                          input int ws);
        bus.REQ  = 1'b1;
        bus.ADDR = addr;
        #1;
        chk({tag, "_stall_req"}, 32'(bus.STALL), 32'd1);
        for (int i = 0; i <= ws; i++) begin
            tick();
            chk({tag, "_cs"},    32'(bus.CS_N),  32'(exp_cs));
            chk({tag, "_sel"},   32'(bus.SEL),   32'(exp_sel));
            chk({tag, "_ack"},   32'(bus.ACK),   (i == ws) ? 32'd1 : 32'd0);
            chk({tag, "_err"},   32'(bus.ERR),   32'd0);
            chk({tag, "_stall"}, 32'(bus.STALL), (i == ws) ? 32'd0 : 32'd1);
            if (i == ws) bus.REQ = 1'b0;
        end
        tick();
        chk({tag, "_cs_end"},  32'(bus.CS_N), 32'hF);
        chk({tag, "_ack_end"}, 32'(bus.ACK),  32'd0);
    endtask

    task automatic unmapped(input string tag, input logic [31:0] addr);
        bus.REQ  = 1'b1;
        bus.ADDR = addr;
        tick();
        chk({tag, "_err"},   32'(bus.ERR),   32'd1);
        chk({tag, "_ack"},   32'(bus.ACK),   32'd1);
        chk({tag, "_cs"},    32'(bus.CS_N),  32'hF);
        chk({tag, "_stall"}, 32'(bus.STALL), 32'd0);
        bus.REQ = 1'b0;
        tick();
        chk({tag, "_err_end"}, 32'(bus.ERR),  32'd0);
        chk({tag, "_ack_end"}, 32'(bus.ACK),  32'd0);
        chk({tag, "_cs_end"},  32'(bus.CS_N), 32'hF);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.REQ  = 1'b1;
        bus.ADDR = 32'h0000_4B00;

        tick();
        tick();
        chk("rst_cs",    32'(bus.CS_N),  32'hF);
        chk("rst_ack",   32'(bus.ACK),   32'd0);
        chk("rst_err",   32'(bus.ERR),   32'd0);
        chk("rst_sel",   32'(bus.SEL),   32'd0);
        chk("rst_stall", 32'(bus.STALL), 32'd1);

        // Held request starts region 0 on the first edge after release.
        rst = 1'b0;
        tick();
        chk("rel_cs",    32'(bus.CS_N),  32'hE);
        chk("rel_ack",   32'(bus.ACK),   32'd1);
        chk("rel_stall", 32'(bus.STALL), 32'd0);
        bus.REQ = 1'b0;
        tick();
        chk("rel_cs_end", 32'(bus.CS_N), 32'hF);
        tick();

        access("r0_ws0",   32'h0000_4B00, 4'b1110, 3'd0, 0);
        access("r1_ws2",   32'h0000_8FFC, 4'b1101, 3'd1, 2);
        access("r3_bound", 32'h0000_4F00, 4'b0111, 3'd3, 3);
        access("r2_top",   32'h0000_FF0F, 4'b1011, 3'd2, 1);
        access("r0_top",   32'h0000_4EFF, 4'b1110, 3'd0, 0);

        unmapped("unm_low",  32'h0000_0100);
        unmapped("unm_r3hi", 32'h0000_5300);
        unmapped("unm_r0lo", 32'h0000_4AFF);
        unmapped("unm_r2hi", 32'h0000_FF10);

        // Address changes after acceptance must not move the select.
        bus.REQ  = 1'b1;
        bus.ADDR = 32'h0000_FF04;
        tick();
        chk("achg_cs1",  32'(bus.CS_N), 32'hB);
        chk("achg_sel1", 32'(bus.SEL),  32'd2);
        chk("achg_ack1", 32'(bus.ACK),  32'd0);
        bus.ADDR = 32'h0000_4B00;
        tick();
        chk("achg_cs2",  32'(bus.CS_N), 32'hB);
        chk("achg_sel2", 32'(bus.SEL),  32'd2);
        chk("achg_ack2", 32'(bus.ACK),  32'd1);
        bus.REQ = 1'b0;
        tick();
        chk("achg_cs_end", 32'(bus.CS_N), 32'hF);

        // Request withdrawn mid-access: the access still completes.
        bus.REQ  = 1'b1;
        bus.ADDR = 32'h0000_8000;
        tick();
        chk("drop_cs1", 32'(bus.CS_N), 32'hD);
        bus.REQ = 1'b0;
        tick();
        chk("drop_cs2",    32'(bus.CS_N),  32'hD);
        chk("drop_ack2",   32'(bus.ACK),   32'd0);
        chk("drop_stall2", 32'(bus.STALL), 32'd0);
        tick();
        chk("drop_cs3",  32'(bus.CS_N), 32'hD);
        chk("drop_ack3", 32'(bus.ACK),  32'd1);
        tick();
        chk("drop_cs_end", 32'(bus.CS_N), 32'hF);

        // Back-to-back: one IDLE cycle with CS_N released between accesses.
        bus.REQ  = 1'b1;
        bus.ADDR = 32'h0000_4B00;
        tick();
        chk("b2b_cs1",  32'(bus.CS_N), 32'hE);
        chk("b2b_ack1", 32'(bus.ACK),  32'd1);
        tick();
        chk("b2b_gap_cs",    32'(bus.CS_N),  32'hF);
        chk("b2b_gap_ack",   32'(bus.ACK),   32'd0);
        chk("b2b_gap_stall", 32'(bus.STALL), 32'd1);
        tick();
        chk("b2b_cs2",  32'(bus.CS_N), 32'hE);
        chk("b2b_ack2", 32'(bus.ACK),  32'd1);
        bus.REQ = 1'b0;
        tick();
        chk("b2b_cs_end", 32'(bus.CS_N), 32'hF);

        // Reset during cycle 2 of a region-3 access.
        bus.REQ  = 1'b1;
        bus.ADDR = 32'h0000_4F00;
        tick();
        chk("mrst_cs1", 32'(bus.CS_N), 32'h7);
        tick();
        chk("mrst_cs2", 32'(bus.CS_N), 32'h7);
        bus.ADDR = 32'h0000_4B00;
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_async_cs",  32'(bus.CS_N), 32'hF);
        chk("mrst_async_ack", 32'(bus.ACK),  32'd0);
        tick();
        chk("mrst_hold_cs",  32'(bus.CS_N), 32'hF);
        chk("mrst_hold_ack", 32'(bus.ACK),  32'd0);
        rst = 1'b0;
        tick();
        chk("mrst_new_cs",  32'(bus.CS_N), 32'hE);
        chk("mrst_new_sel", 32'(bus.SEL),  32'd0);
        chk("mrst_new_ack", 32'(bus.ACK),  32'd1);
        bus.REQ = 1'b0;
        tick();
        chk("mrst_new_cs_end", 32'(bus.CS_N), 32'hF);
        chk("mrst_new_ack_end", 32'(bus.ACK), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
